// File: rtl/race_pkg.sv
// race_pkg: shared types and helpers for the race-logic time decoder.
// Holds the decoder state encoding and the INF (never-fired) value helper.
package race_pkg;

  // Decoder control states: waiting for a window, timing a window, holding a result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WINDOW = 2'd1,
    HOLD   = 2'd2
  } dec_state_t;

  // Timestamp value reported by a lane that never fired: all ones in a TW-bit field.
  function automatic int unsigned inf_val(input int unsigned tw);
    return (32'd1 << tw) - 32'd1;
  endfunction

endpackage

// File: rtl/race_sync.sv
// race_sync: STAGES-deep per-bit synchronizer for asynchronous race-logic lanes.
// RST_VAL lets idle-high lanes come out of reset already at their idle level,
// so that a falling-edge encoding does not see a spurious edge after reset.
module race_sync #(
  parameter int   WIDTH   = 2,
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift each lane through the flop chain; the first stage may go metastable,
  // later stages give it a full cycle to settle before the decoder sees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        stage_q[s] <= {WIDTH{RST_VAL}};
      end
    end else begin
      stage_q[0] <= d;
      for (int s = 1; s < STAGES; s++) begin
        stage_q[s] <= stage_q[s-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/race_time_decoder.sv
// race_time_decoder: turns race-logic edge arrival times into binary timestamps.
// A single-cycle 'set' opens a GAMMA-cycle window; each lane's first active
// cycle is recorded as a count of aclk cycles from the window start. Lanes that
// never fire report INF (all ones). Results are offered through out_valid/out_ready.
// Build option: define RACE_FALLING_EN for falling-edge (active-low) lanes;
// the default build uses rising-edge (active-high) lanes.
module race_time_decoder
  import race_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int TW          = 5,
  parameter int GAMMA       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                aclk,
  input  logic                grst,
  input  logic                set,
  input  logic [LANES-1:0]    sig,
  output logic [LANES*TW-1:0] out_time,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                overrun
);

  // State encodings kept as plain constants so the state register is a bare vector.
  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_WINDOW = WINDOW;
  localparam logic [1:0] ST_HOLD   = HOLD;

  localparam logic [TW-1:0] INF  = {TW{1'b1}};
  localparam logic [TW-1:0] LAST = TW'(GAMMA - 1);

  // Reject window lengths that cannot be counted in TW bits without reaching past INF,
  // and synchronizers too shallow to resolve metastability.
  if (GAMMA < 1 || $unsigned(GAMMA) > inf_val(TW)) begin : g_bad_gamma
    $error("race_time_decoder: GAMMA must be in 1..2^TW-1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("race_time_decoder: SYNC_STAGES must be at least 2");
  end

`ifdef RACE_FALLING_EN
  localparam logic SYNC_RST = 1'b1;
`else
  localparam logic SYNC_RST = 1'b0;
`endif

  logic [1:0]       state;
  logic [TW-1:0]    counter;
  logic [LANES-1:0] flag;
  logic [TW-1:0]    time_q [LANES];
  logic [LANES-1:0] sync_sig;
  logic [LANES-1:0] active;

  race_sync #(
    .WIDTH   (LANES),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (SYNC_RST)
  ) u_sync (
    .clk   (aclk),
    .rst_n (grst),
    .d     (sig),
    .q     (sync_sig)
  );

`ifdef RACE_FALLING_EN
  assign active = ~sync_sig;
`else
  assign active = sync_sig;
`endif

  // Window control and per-lane capture. Every lane gets exactly one value per
  // window: its first active cycle, or INF once the last window cycle passes.
  // A set that arrives outside IDLE (including the handshake cycle) is dropped
  // and flagged for one cycle so the producer knows a request was lost.
  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      state   <= ST_IDLE;
      counter <= '0;
      flag    <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        time_q[i] <= '0;
      end
    end else begin
      overrun <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (set) begin
            state   <= ST_WINDOW;
            counter <= '0;
            flag    <= '0;
          end
        end
        ST_WINDOW: begin
          if (set) begin
            overrun <= 1'b1;
          end
          for (int i = 0; i < LANES; i++) begin
            if (!flag[i] && active[i]) begin
              time_q[i] <= counter;
              flag[i]   <= 1'b1;
            end else if (!flag[i] && counter == LAST) begin
              time_q[i] <= INF;
            end
          end
          counter <= counter + 1'b1;
          if (counter == LAST) begin
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (set) begin
            overrun <= 1'b1;
          end
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Present all lanes side by side, lane i in bits [i*TW +: TW].
  always_comb begin
    out_time = '0;
    for (int i = 0; i < LANES; i++) begin
      out_time[i*TW +: TW] = time_q[i];
    end
  end

  assign out_valid = (state == ST_HOLD);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_race_time_decoder.sv
// tb_race_time_decoder: directed, table-driven bench for race_time_decoder
// (LANES=2, TW=5, GAMMA=16, SYNC_STAGES=2). Honours RACE_FALLING_EN.
module tb_race_time_decoder;

  logic       aclk;
  logic       grst;
  logic       set;
  logic [1:0] sig;
  logic [9:0] out_time;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       overrun;

  int n_cmp;
  int n_bad;

`ifdef RACE_FALLING_EN
  localparam logic IDLE_LVL = 1'b1;
`else
  localparam logic IDLE_LVL = 1'b0;
`endif
  localparam logic FIRE_LVL = ~IDLE_LVL;

  typedef struct {
    int         t0;
    int         t1;
    logic [4:0] e0;
    logic [4:0] e1;
  } vec_t;

  vec_t vecs [8];

  race_time_decoder #(
    .LANES       (2),
    .TW          (5),
    .GAMMA       (16),
    .SYNC_STAGES (2)
  ) dut (
    .aclk      (aclk),
    .grst      (grst),
    .set       (set),
    .sig       (sig),
    .out_time  (out_time),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  // 10 ns clock
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Compare one observed value against its expected value and log mismatches.
  task automatic checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Run one full window. t = cycle the lane fires, -1 = never, -2 = already
  // active before set. Checks result latency, timestamps and the handshake.
  task automatic applyStimulus(input int t0, input int t1,
                               input logic [4:0] e0, input logic [4:0] e1,
                               input string tag);
    sig[0]    = (t0 == -2) ? FIRE_LVL : IDLE_LVL;
    sig[1]    = (t1 == -2) ? FIRE_LVL : IDLE_LVL;
    out_ready = 1'b0;
    repeat (3) step();
    set = 1'b1;
    step();
    set = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      if (k == 0)  checkOutput({tag, " busy_start"}, int'(busy), 1);
      if (k == 15) checkOutput({tag, " valid_early"}, int'(out_valid), 0);
      if (k == 16) begin
        checkOutput({tag, " valid_at_set+17"}, int'(out_valid), 1);
        checkOutput({tag, " lane0"}, int'(out_time[4:0]), int'(e0));
        checkOutput({tag, " lane1"}, int'(out_time[9:5]), int'(e1));
      end
      if (t0 == k) sig[0] = FIRE_LVL;
      if (t1 == k) sig[1] = FIRE_LVL;
      if (k < 16) step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput({tag, " valid_after_hs"}, int'(out_valid), 0);
    checkOutput({tag, " busy_after_hs"}, int'(busy), 0);
    sig = {IDLE_LVL, IDLE_LVL};
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    set       = 1'b0;
    out_ready = 1'b0;
    sig       = {IDLE_LVL, IDLE_LVL};
    grst      = 1'b0;

    vecs[0] = '{t0:  3, t1: -1, e0:  5, e1: 31};
    vecs[1] = '{t0:  6, t1:  1, e0:  8, e1:  3};
    vecs[2] = '{t0: -2, t1: -2, e0:  0, e1:  0};
    vecs[3] = '{t0:  4, t1:  4, e0:  6, e1:  6};
    vecs[4] = '{t0:  0, t1: -1, e0:  2, e1: 31};
    vecs[5] = '{t0: 14, t1: 13, e0: 31, e1: 15};
    vecs[6] = '{t0:  2, t1: -1, e0:  4, e1: 31};
    vecs[7] = '{t0: -1, t1: -1, e0: 31, e1: 31};

    // Reset state
    #12;
    checkOutput("reset out_time", int'(out_time), 0);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset overrun", int'(overrun), 0);
    grst = 1'b1;
    step();

    // Table of directed windows
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].t0, vecs[v].t1, vecs[v].e0, vecs[v].e1,
                    $sformatf("vec%0d", v));
    end

    // Overrun in WINDOW, overrun in HOLD with ready low, and a set on the handshake cycle
    repeat (3) step();
    set = 1'b1;
    step();
    set = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 2) sig[0] = FIRE_LVL;
      if (k == 5) set = 1'b1;
      if (k == 6) begin
        set = 1'b0;
        checkOutput("ovr window pulse", int'(overrun), 1);
        checkOutput("ovr window busy", int'(busy), 1);
      end
      if (k == 7) checkOutput("ovr window pulse end", int'(overrun), 0);
      step();
    end
    for (int h = 0; h < 10; h++) begin
      checkOutput($sformatf("hold%0d valid", h), int'(out_valid), 1);
      checkOutput($sformatf("hold%0d lane0", h), int'(out_time[4:0]), 4);
      checkOutput($sformatf("hold%0d lane1", h), int'(out_time[9:5]), 31);
      if (h == 3) set = 1'b1;
      if (h == 4) begin
        set = 1'b0;
        checkOutput("ovr hold pulse", int'(overrun), 1);
      end
      if (h == 5) checkOutput("ovr hold pulse end", int'(overrun), 0);
      step();
    end
    set       = 1'b1;
    out_ready = 1'b1;
    step();
    set       = 1'b0;
    out_ready = 1'b0;
    checkOutput("hs+set valid", int'(out_valid), 0);
    checkOutput("hs+set busy", int'(busy), 0);
    checkOutput("hs+set overrun", int'(overrun), 1);
    step();
    checkOutput("hs+set no restart", int'(busy), 0);
    checkOutput("hs+set overrun end", int'(overrun), 0);
    sig = {IDLE_LVL, IDLE_LVL};

    // Asynchronous reset in the middle of a window
    repeat (3) step();
    set = 1'b1;
    step();
    set = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k == 1) sig[0] = FIRE_LVL;
      step();
    end
    checkOutput("pre-abort busy", int'(busy), 1);
    grst = 1'b0;
    #1;
    checkOutput("abort out_time", int'(out_time), 0);
    checkOutput("abort out_valid", int'(out_valid), 0);
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort overrun", int'(overrun), 0);
    #2;
    grst = 1'b1;
    sig  = {IDLE_LVL, IDLE_LVL};
    step();
    applyStimulus(5, 9, 5'd7, 5'd11, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no completion, expected completion before 200000 ns");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/race_time_decoder.md
Name: race_time_decoder

Overview:
- Downstream consumer of the temporal (race-logic) compare stages such as the exclusive-max cell.
- Converts per-lane edge arrival times inside a gamma window into binary timestamps, counted in aclk cycles from the window start.
- Presents all lanes' timestamps together through a valid/ready handshake to the binary side of the design.
- Lanes that never fire within the window report INF (all ones).

Parameters:
- LANES, 2: number of race-logic input lanes.
- TW, 5: timestamp width in bits; INF = 2^TW-1.
- GAMMA, 16: window length in aclk cycles; legal range 1..2^TW-1, checked by elaboration assertion.
- SYNC_STAGES, 2: synchronizer depth on each sig lane; legal minimum 2.

Ports:
- aclk  in  1  clock.
- grst  in  1  reset; asynchronous, active-low.
- set  in  1  single-cycle window start, synchronous to aclk.
- sig  in  LANES  asynchronous race-logic lanes, monotonic within a window.
- out_time  out  LANES*TW  packed timestamps; lane i occupies [i*TW +: TW].
- out_valid  out  1  timestamps available.
- out_ready  in  1  consumer accepts.
- busy  out  1  window in progress or result held.
- overrun  out  1  one-cycle pulse when a set is dropped.

Behaviour:
- Reset (grst=0, asynchronous): state=IDLE, counter=0, all capture flags=0, out_time=0, out_valid=0, busy=0, overrun=0, synchronizer flops=0.
- Each lane passes through SYNC_STAGES flops; sync_sig is the last stage.
- FSM states: IDLE, WINDOW, HOLD.
- IDLE:
  - set=1 -> WINDOW; counter=0; capture flags cleared.
  - busy=0.
- WINDOW (busy=1):
  - Each cycle, for every lane i with flag=0 and active(sync_sig[i])=1: time[i]=counter, flag[i]=1.
  - Rising polarity: active(x)=x.
  - Level capture: a lane already active at window cycle 0 captures 0.
  - Captured values are never overwritten within a window, even if the lane deasserts.
  - counter increments each cycle.
  - When counter==GAMMA-1, that cycle is evaluated, then all lanes with flag=0 get time=INF -> HOLD.
  - The window always runs the full GAMMA cycles; there is no early exit when all lanes have fired.
- HOLD:
  - out_valid=1; out_time is stable.
  - out_valid&&out_ready -> IDLE on the next edge, with out_valid=0.
- A result is a single HOLD period: first out_valid cycle = set cycle + GAMMA + 1.
- set outside IDLE (WINDOW or HOLD) is ignored and overrun pulses for one cycle.
- A set in the same cycle as the HOLD->IDLE handshake is also ignored, with overrun pulse; no same-cycle restart.
- Counter width is TW. Because GAMMA <= INF, no wrap occurs.
- Reset asserted mid-window or mid-hold aborts immediately; no partial result is emitted.

Optional Feature:
- Macro RACE_FALLING_EN.
- Defined: falling-edge encoding, active(x)=~x. Synchronizer flops reset to 1, so an idle-high line does not fire spuriously after reset.
- Undefined: rising-edge encoding, active(x)=x; synchronizer flops reset to 0.
- All other behaviour is identical in both builds.

Decomposition:
- Package race_pkg holds:
  - state enum dec_state_t {IDLE, WINDOW, HOLD};
  - localparam function inf_val(TW) returning 2^TW-1.
- One sub-module, race_sync: SYNC_STAGES-deep per-bit synchronizer with asynchronous active-low reset and a reset-value parameter. Instantiated once, LANES wide.
- Everything else is inline in race_time_decoder.

Test Plan (LANES=2, TW=5, GAMMA=16, SYNC_STAGES=2):
Stimulus timing: the bench drives sig right after an aclk edge. A change made in window cycle n appears as capture value n+2.
- Reset, pulse set, raise sig[0] in window cycle 3, sig[1] never -> out_time lane0=5, lane1=31; out_valid rises at set+17.
- Raise sig[1] in cycle 1, then sig[0] in cycle 6 -> lane1=3, lane0=8.
- Both lanes high before set -> both 0. Both raised in the same cycle 4 -> both 6.
- Hold out_ready=0 for 10 cycles and pulse set during WINDOW and during HOLD -> two overrun pulses; out_time stable; single handshake when ready=1.
- Deassert grst mid-window at cycle 7 -> all outputs 0 asynchronously. A fresh set then yields a correct new result.
- RACE_FALLING_EN build: reset with lanes high, drop sig[0] in cycle 2 -> lane0=4, lane1=31.
